// File: rtl/merge_n_pkg.sv
// Shared constants for the N-input merge: arbitration modes, skid depth and
// the source-ID width rule (never narrower than one bit).
package merge_pkg;

    localparam int ARB_FIXED  = 0;
    localparam int ARB_RR     = 1;
    localparam int SKID_DEPTH = 2;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/merge_n_if.sv
// Upstream FIFO read side plus downstream FIFO write side of the merge.
// master = the merge itself, slave = the surrounding FIFOs.
interface merge_n_if import merge_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_INPUTS = 4,
    parameter int ID_WIDTH   = id_width(NUM_INPUTS)
);
    logic [NUM_INPUTS*DATA_WIDTH-1:0] din;
    logic [NUM_INPUTS-1:0]            buffer_empty;
    logic [NUM_INPUTS-1:0]            read_en;
    logic                             buffer_out_full;
    logic [DATA_WIDTH-1:0]            dout;
    logic [ID_WIDTH-1:0]              dout_src;
    logic                             wen;

    modport master (
        input  din, buffer_empty, buffer_out_full,
        output read_en, dout, dout_src, wen
    );

    modport slave (
        output din, buffer_empty, buffer_out_full,
        input  read_en, dout, dout_src, wen
    );
endinterface

// File: rtl/merge_n_rr_arbiter.sv
// One-hot grant over N requesters. Round-robin searches from last_grant+1;
// fixed priority is the same search with the pointer frozen at N-1.
module rr_arbiter import merge_pkg::*; #(
    parameter int N    = 4,
    parameter int MODE = ARB_FIXED,
    parameter int IW   = id_width(N)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_id
);
    logic [IW-1:0] last_grant;
    int            best_pos;

    // Distance of channel c from the search start (last_grant+1), modulo N.
    function automatic int rank(input int c, input logic [IW-1:0] ptr);
        return (c + N - 1 - int'(ptr)) % N;
    endfunction

    if (MODE == ARB_RR) begin : g_ptr
        always_ff @(posedge clk) begin
            if (!reset_n)
                last_grant <= IW'(N - 1);
            else if (advance)
                last_grant <= grant_id;
        end
    end else begin : g_fixed
        logic unused_ptr_inputs;
        assign unused_ptr_inputs = ^{clk, reset_n, advance};
        assign last_grant        = IW'(N - 1);
    end

    always_comb begin
        grant    = '0;
        grant_id = '0;
        best_pos = N;
        for (int c = 0; c < N; c++) begin
            if (req[c] && rank(c, last_grant) < best_pos) begin
                best_pos = rank(c, last_grant);
                grant    = '0;
                grant[c] = 1'b1;
                grant_id = IW'(c);
            end
        end
    end

endmodule

// File: rtl/merge_n.sv
// N-input merge: arbitrates reads from N latency-1 source FIFOs into one
// downstream FIFO through a 2-entry skid queue, one word per cycle.
module merge_n import merge_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_INPUTS = 4,
    parameter int ARB_MODE   = ARB_FIXED,
    parameter int ID_WIDTH   = id_width(NUM_INPUTS)
) (
    input  logic      clk,
    input  logic      reset_n,
    merge_n_if.master bus
);
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ID_WIDTH-1:0]   src;
    } skid_entry_t;

    logic [NUM_INPUTS-1:0] req;
    logic [NUM_INPUTS-1:0] grant;
    logic [ID_WIDTH-1:0]   grant_id;
    logic [ID_WIDTH-1:0]   inflight_id;
    logic [1:0]            count;
    logic                  inflight;
    logic                  issue;
    logic                  pop;
    logic                  push;
    logic [2:0]            credit_used;
    skid_entry_t           skid_head;
    skid_entry_t           skid_tail;
    skid_entry_t           push_entry;

    assign req  = ~bus.buffer_empty;
    assign pop  = (count != 2'd0) && !bus.buffer_out_full;
    assign push = inflight;

    // A word in flight already owns a skid slot, so the credit counts it;
    // the slot freed by this cycle's pop can be reused immediately.
    assign credit_used = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    assign issue       = (|req) && (credit_used < 3'(SKID_DEPTH));

    rr_arbiter #(
        .N    (NUM_INPUTS),
        .MODE (ARB_MODE),
        .IW   (ID_WIDTH)
    ) u_arb (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .advance  (issue),
        .grant    (grant),
        .grant_id (grant_id)
    );

    always_comb begin
        push_entry.src  = inflight_id;
        push_entry.data = '0;
        for (int c = 0; c < NUM_INPUTS; c++) begin
            if (inflight_id == ID_WIDTH'(c))
                push_entry.data = bus.din[c*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count       <= 2'd0;
            inflight    <= 1'b0;
            inflight_id <= '0;
            skid_head   <= '0;
            skid_tail   <= '0;
        end else begin
            inflight <= issue;
            if (issue)
                inflight_id <= grant_id;

            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0)
                        skid_head <= push_entry;
                    else
                        skid_tail <= push_entry;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    skid_head <= skid_tail;
                    count     <= count - 2'd1;
                end
                2'b11: begin
                    // Occupancy stays put; the new word goes behind whatever remains.
                    if (count == 2'd1) begin
                        skid_head <= push_entry;
                    end else begin
                        skid_head <= skid_tail;
                        skid_tail <= push_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.read_en  = issue ? grant : '0;
    assign bus.wen      = pop;
    assign bus.dout     = skid_head.data;
    assign bus.dout_src = skid_head.src;

endmodule

// File: tb/tb_merge_n.sv
// Bench for merge_n: three configurations (fixed N=3, round-robin N=4, N=1)
// fed by latency-1 source FIFO models; directed scenarios plus a random scoreboard.
module tb_merge_n;
    import merge_pkg::*;

    localparam int DW = 16;

    logic clk;
    logic reset_n;
    int   n_chk;
    int   n_pass;

    merge_n_if #(.DATA_WIDTH(DW), .NUM_INPUTS(3), .ID_WIDTH(2)) if_fix ();
    merge_n_if #(.DATA_WIDTH(DW), .NUM_INPUTS(4), .ID_WIDTH(2)) if_rr  ();
    merge_n_if #(.DATA_WIDTH(DW), .NUM_INPUTS(1), .ID_WIDTH(1)) if_one ();

    merge_n #(.DATA_WIDTH(DW), .NUM_INPUTS(3), .ARB_MODE(ARB_FIXED), .ID_WIDTH(2))
        u_fix (.clk(clk), .reset_n(reset_n), .bus(if_fix));
    merge_n #(.DATA_WIDTH(DW), .NUM_INPUTS(4), .ARB_MODE(ARB_RR), .ID_WIDTH(2))
        u_rr  (.clk(clk), .reset_n(reset_n), .bus(if_rr));
    merge_n #(.DATA_WIDTH(DW), .NUM_INPUTS(1), .ARB_MODE(ARB_FIXED), .ID_WIDTH(1))
        u_one (.clk(clk), .reset_n(reset_n), .bus(if_one));

    // Source FIFO models, indexed [dut][channel]; dut 0=fixed, 1=rr, 2=single.
    logic [DW-1:0] mem  [3][4][256];
    int            wp   [3][4];
    int            rp   [3][4];
    logic [DW-1:0] dreg [3][4];
    logic [3:0]    emp  [3];
    logic [3:0]    ren  [3];
    logic          wen_o  [3];
    logic [DW-1:0] dout_o [3];
    logic [1:0]    src_o  [3];
    logic          full_i [3];

    assign ren[0]    = {1'b0, if_fix.read_en};
    assign ren[1]    = if_rr.read_en;
    assign ren[2]    = {3'b0, if_one.read_en};
    assign wen_o[0]  = if_fix.wen;
    assign wen_o[1]  = if_rr.wen;
    assign wen_o[2]  = if_one.wen;
    assign dout_o[0] = if_fix.dout;
    assign dout_o[1] = if_rr.dout;
    assign dout_o[2] = if_one.dout;
    assign src_o[0]  = if_fix.dout_src;
    assign src_o[1]  = if_rr.dout_src;
    assign src_o[2]  = {1'b0, if_one.dout_src};

    assign if_fix.buffer_empty    = emp[0][2:0];
    assign if_rr.buffer_empty     = emp[1];
    assign if_one.buffer_empty    = emp[2][0];
    assign if_fix.din             = {dreg[0][2], dreg[0][1], dreg[0][0]};
    assign if_rr.din              = {dreg[1][3], dreg[1][2], dreg[1][1], dreg[1][0]};
    assign if_one.din             = dreg[2][0];
    assign if_fix.buffer_out_full = full_i[0];
    assign if_rr.buffer_out_full  = full_i[1];
    assign if_one.buffer_out_full = full_i[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int d = 0; d < 3; d++)
            for (int c = 0; c < 4; c++)
                emp[d][c] = (rp[d][c] == wp[d][c]);
    end

    // Sources reset with the system: contents flushed, output register cleared.
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < 4; c++) begin
                if (!reset_n) begin
                    rp[d][c]   <= wp[d][c];
                    dreg[d][c] <= '0;
                end else if (ren[d][c] && rp[d][c] != wp[d][c]) begin
                    dreg[d][c] <= mem[d][c][rp[d][c] % 256];
                    rp[d][c]   <= rp[d][c] + 1;
                end
            end
        end
    end

    task automatic push_word(input int d, input int c, input logic [DW-1:0] w);
        mem[d][c][wp[d][c] % 256] = w;
        wp[d][c] = wp[d][c] + 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        for (int d = 0; d < 3; d++) full_i[d] = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            n_chk++; if (ren[d] !== 4'b0) $display("FAIL reset_read_en dut%0d: got %b exp 0", d, ren[d]); else n_pass++;
            n_chk++; if (wen_o[d] !== 1'b0) $display("FAIL reset_wen dut%0d: got %b exp 0", d, wen_o[d]); else n_pass++;
            n_chk++; if (dout_o[d] !== '0) $display("FAIL reset_dout dut%0d: got %h exp 0", d, dout_o[d]); else n_pass++;
            n_chk++; if (src_o[d] !== 2'd0) $display("FAIL reset_src dut%0d: got %0d exp 0", d, src_o[d]); else n_pass++;
        end
    endtask

    task automatic test_fixed_order();
        logic [3:0]    e_ren;
        logic          e_wen;
        logic [DW-1:0] e_dout;
        do_reset();
        for (int c = 0; c < 3; c++)
            for (int j = 0; j < 2; j++) push_word(0, c, 16'(16'hA0 + 16*c + j));
        for (int k = 0; k < 10; k++) begin
            #1;
            e_ren = (k < 6) ? 4'(1 << (k / 2)) : 4'b0;
            e_wen = (k >= 2) && (k < 8);
            n_chk++; if (ren[0] !== e_ren) $display("FAIL fixed_read_en k=%0d: got %b exp %b", k, ren[0], e_ren); else n_pass++;
            n_chk++; if (wen_o[0] !== e_wen) $display("FAIL fixed_wen k=%0d: got %b exp %b", k, wen_o[0], e_wen); else n_pass++;
            if (e_wen) begin
                e_dout = 16'(16'hA0 + 16*((k-2)/2) + (k-2)%2);
                n_chk++; if (dout_o[0] !== e_dout) $display("FAIL fixed_dout k=%0d: got %h exp %h", k, dout_o[0], e_dout); else n_pass++;
                n_chk++; if (src_o[0] !== 2'((k-2)/2)) $display("FAIL fixed_src k=%0d: got %0d exp %0d", k, src_o[0], (k-2)/2); else n_pass++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_rr_order();
        logic [3:0]    e_ren;
        logic [DW-1:0] e_dout;
        int            i;
        do_reset();
        for (int c = 0; c < 4; c++)
            for (int j = 0; j < 8; j++) push_word(1, c, 16'(c*256 + j));
        for (int k = 0; k < 10; k++) begin
            #1;
            e_ren = 4'(1 << (k % 4));
            n_chk++; if (ren[1] !== e_ren) $display("FAIL rr_read_en k=%0d: got %b exp %b", k, ren[1], e_ren); else n_pass++;
            n_chk++; if (wen_o[1] !== (k >= 2)) $display("FAIL rr_wen k=%0d: got %b exp %b", k, wen_o[1], k >= 2); else n_pass++;
            if (k >= 2) begin
                i      = k - 2;
                e_dout = 16'((i % 4)*256 + i / 4);
                n_chk++; if (src_o[1] !== 2'(i % 4)) $display("FAIL rr_src k=%0d: got %0d exp %0d", k, src_o[1], i % 4); else n_pass++;
                n_chk++; if (dout_o[1] !== e_dout) $display("FAIL rr_dout k=%0d: got %h exp %h", k, dout_o[1], e_dout); else n_pass++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] ren_map;
        logic [15:0] wen_map;
        int          n_wr;
        ren_map = 16'h0F0F;
        wen_map = 16'h3F0C;
        n_wr    = 0;
        do_reset();
        for (int j = 1; j <= 8; j++) push_word(2, 0, 16'(j));
        for (int k = 0; k < 16; k++) begin
            full_i[2] = (k >= 4) && (k <= 7);
            #1;
            n_chk++; if (ren[2][0] !== ren_map[k]) $display("FAIL bp_read_en k=%0d: got %b exp %b", k, ren[2][0], ren_map[k]); else n_pass++;
            n_chk++; if (wen_o[2] !== wen_map[k]) $display("FAIL bp_wen k=%0d: got %b exp %b", k, wen_o[2], wen_map[k]); else n_pass++;
            n_chk++; if (u_one.count > 2'd2) $display("FAIL bp_count k=%0d: got %0d exp <=2", k, u_one.count); else n_pass++;
            if (wen_map[k]) begin
                n_wr++;
                n_chk++; if (dout_o[2] !== 16'(n_wr)) $display("FAIL bp_dout k=%0d: got %h exp %h", k, dout_o[2], n_wr); else n_pass++;
            end
            @(negedge clk);
        end
        full_i[2] = 1'b0;
    endtask

    task automatic test_single_input();
        do_reset();
        for (int j = 0; j < 5; j++) push_word(2, 0, 16'(16'h11 + j));
        for (int k = 0; k < 9; k++) begin
            #1;
            n_chk++; if (ren[2][0] !== (k < 5)) $display("FAIL n1_read_en k=%0d: got %b exp %b", k, ren[2][0], k < 5); else n_pass++;
            n_chk++; if (wen_o[2] !== (k >= 2 && k < 7)) $display("FAIL n1_wen k=%0d: got %b exp %b", k, wen_o[2], k >= 2 && k < 7); else n_pass++;
            if (k >= 2 && k < 7) begin
                n_chk++; if (dout_o[2] !== 16'(16'h11 + k - 2)) $display("FAIL n1_dout k=%0d: got %h exp %h", k, dout_o[2], 16'h11 + k - 2); else n_pass++;
                n_chk++; if (src_o[2] !== 2'd0) $display("FAIL n1_src k=%0d: got %0d exp 0", k, src_o[2]); else n_pass++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_rr_fairness();
        logic [3:0] e_ren;
        int         issues;
        int         ch2_at;
        issues = 0;
        ch2_at = -1;
        do_reset();
        for (int j = 0; j < 16; j++) push_word(1, 0, 16'(16'h0100 + j));
        push_word(1, 2, 16'h2222);
        for (int k = 0; k < 6; k++) begin
            #1;
            e_ren = (k == 1) ? 4'b0100 : 4'b0001;
            n_chk++; if (ren[1] !== e_ren) $display("FAIL fair_read_en k=%0d: got %b exp %b", k, ren[1], e_ren); else n_pass++;
            if (ren[1][2] && ch2_at < 0) ch2_at = issues;
            if (ren[1] != 4'b0) issues++;
            if (k == 3) begin
                n_chk++; if (src_o[1] !== 2'd2) $display("FAIL fair_src: got %0d exp 2", src_o[1]); else n_pass++;
                n_chk++; if (dout_o[1] !== 16'h2222) $display("FAIL fair_dout: got %h exp 2222", dout_o[1]); else n_pass++;
            end
            @(negedge clk);
        end
        n_chk++; if (ch2_at < 0 || ch2_at > 3) $display("FAIL fair_latency: got issue %0d exp within 4", ch2_at); else n_pass++;
    endtask

    task automatic test_reset_midstream();
        do_reset();
        full_i[1] = 1'b1;
        for (int c = 0; c < 4; c++)
            for (int j = 0; j < 4; j++) push_word(1, c, 16'(16'h4000 + 16*c + j));
        for (int k = 0; k < 3; k++) begin
            #1;
            n_chk++; if (ren[1] !== ((k < 2) ? 4'(1 << k) : 4'b0)) $display("FAIL mid_read_en k=%0d: got %b", k, ren[1]); else n_pass++;
            n_chk++; if (wen_o[1] !== 1'b0) $display("FAIL mid_wen k=%0d: got %b exp 0", k, wen_o[1]); else n_pass++;
            if (k < 2) @(negedge clk);
        end
        // A word is in flight and one is held in the skid queue here.
        reset_n = 1'b0;
        @(negedge clk);
        reset_n   = 1'b1;
        full_i[1] = 1'b0;
        #1;
        n_chk++; if (wen_o[1] !== 1'b0) $display("FAIL rst_wen: got %b exp 0", wen_o[1]); else n_pass++;
        n_chk++; if (ren[1] !== 4'b0) $display("FAIL rst_read_en: got %b exp 0", ren[1]); else n_pass++;
        n_chk++; if (dout_o[1] !== '0) $display("FAIL rst_dout: got %h exp 0", dout_o[1]); else n_pass++;
        for (int c = 0; c < 4; c++) push_word(1, c, 16'(16'h5000 + c));
        #1;
        n_chk++; if (ren[1] !== 4'b0001) $display("FAIL rst_rr_restart: got %b exp 0001", ren[1]); else n_pass++;
        @(negedge clk);
        #1;
        n_chk++; if (ren[1] !== 4'b0010) $display("FAIL rst_rr_next: got %b exp 0010", ren[1]); else n_pass++;
        n_chk++; if (wen_o[1] !== 1'b0) $display("FAIL rst_no_stale: got %b exp 0", wen_o[1]); else n_pass++;
        @(negedge clk);
        #1;
        n_chk++; if (wen_o[1] !== 1'b1) $display("FAIL rst_first_wen: got %b exp 1", wen_o[1]); else n_pass++;
        n_chk++; if (dout_o[1] !== 16'h5000) $display("FAIL rst_first_dout: got %h exp 5000", dout_o[1]); else n_pass++;
    endtask

    // Scoreboard: words leave in issue order; issue follows the credit rule
    // (outstanding words minus this cycle's write < 2) and the arbitration order.
    task automatic test_random(input int d);
        logic [17:0] expq[$];
        logic [17:0] front;
        logic [3:0]  req;
        logic [3:0]  e_ren;
        logic        e_wen;
        logic        e_iss;
        logic        last_iss;
        int          nch;
        int          mode;
        int          ptr;
        int          e_ch;
        int          busy;
        nch      = (d == 0) ? 3 : (d == 1) ? 4 : 1;
        mode     = (d == 1) ? ARB_RR : ARB_FIXED;
        ptr      = nch - 1;
        last_iss = 1'b0;
        do_reset();
        for (int k = 0; k < 300; k++) begin
            full_i[d] = (k < 260) && ($urandom_range(0, 3) == 0);
            for (int c = 0; c < nch; c++)
                if (k < 260 && $urandom_range(0, 2) == 0 && wp[d][c] - rp[d][c] < 8)
                    push_word(d, c, 16'($urandom()));
            #1;
            req   = ~emp[d] & 4'((1 << nch) - 1);
            busy  = expq.size() - (last_iss ? 1 : 0);
            e_wen = (busy != 0) && !full_i[d];
            e_iss = (req != 4'b0) && (expq.size() - (e_wen ? 1 : 0) < 2);
            e_ch  = -1;
            if (e_iss) begin
                for (int i = 0; i < nch; i++) begin
                    int c;
                    c = (mode == ARB_RR) ? (ptr + 1 + i) % nch : i;
                    if (e_ch < 0 && req[c]) e_ch = c;
                end
            end
            e_ren = (e_ch >= 0) ? 4'(1 << e_ch) : 4'b0;
            n_chk++; if (ren[d] !== e_ren) $display("FAIL rand%0d_read_en k=%0d: got %b exp %b", d, k, ren[d], e_ren); else n_pass++;
            n_chk++; if (wen_o[d] !== e_wen) $display("FAIL rand%0d_wen k=%0d: got %b exp %b", d, k, wen_o[d], e_wen); else n_pass++;
            if (e_wen) begin
                front = expq.pop_front();
                n_chk++;
                if ({src_o[d], dout_o[d]} !== front)
                    $display("FAIL rand%0d_word k=%0d: got src %0d data %h exp src %0d data %h",
                             d, k, src_o[d], dout_o[d], front[17:16], front[15:0]);
                else n_pass++;
            end
            if (e_ch >= 0) begin
                expq.push_back({2'(e_ch), mem[d][e_ch][rp[d][e_ch] % 256]});
                ptr = e_ch;
            end
            last_iss = (e_ch >= 0);
            @(negedge clk);
        end
    endtask

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        reset_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            full_i[d] = 1'b0;
            for (int c = 0; c < 4; c++) wp[d][c] = 0;
        end
        test_reset();
        test_fixed_order();
        test_rr_order();
        test_backpressure();
        test_single_input();
        test_rr_fairness();
        test_reset_midstream();
        test_random(0);
        test_random(1);
        test_random(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
